// File: rtl/code_lock_pkg.sv
`default_nettype none
// ============================================================================
// Package  : code_lock_pkg
// Brief    : Shared state encoding, widths and code constants for the lock.
// Revision : 1.0 - initial release
// ============================================================================
package code_lock_pkg;

   localparam int DIGIT_W    = 4;
   localparam int DIGITS_DEF = 4;
   localparam int ENTRY_W    = DIGIT_W * DIGITS_DEF;

   localparam logic [ENTRY_W-1:0] ENTRY_EMPTY      = 16'hFFFF;
   localparam logic [ENTRY_W-1:0] DEFAULT_CODE_VAL = 16'h1234;
   localparam logic [ENTRY_W-1:0] ADMIN_KEY_VAL    = 16'h9999;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ENTRY   = 3'd1,
      ST_CHECK   = 3'd2,
      ST_OPEN    = 3'd3,
      ST_LOCKOUT = 3'd4,
      ST_PROG    = 3'd5
   } state_e;

   function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
      return (d <= 4'd9);
   endfunction

endpackage
`default_nettype wire

// File: rtl/code_lock_if.sv
`default_nettype none
// ============================================================================
// Interface : code_lock_if
// Brief     : Event/button inputs and status outputs of the code lock.
// Revision  : 1.0 - initial release
// ============================================================================
interface code_lock_if;
   import code_lock_pkg::*;

   logic               evt_valid;
   logic [DIGIT_W-1:0] evt_digit;
   logic               btn_enter;
   logic               btn_clear;
   logic               admin_mode;
   logic               unlock;
   logic               alarm;
   logic               err_pulse;
   logic [2:0]         state;
   logic [2:0]         digit_cnt;
   logic [1:0]         fail_cnt;
   logic [ENTRY_W-1:0] entry;

   modport master (
      output evt_valid, evt_digit, btn_enter, btn_clear, admin_mode,
      input  unlock, alarm, err_pulse, state, digit_cnt, fail_cnt, entry
   );

   modport slave (
      input  evt_valid, evt_digit, btn_enter, btn_clear, admin_mode,
      output unlock, alarm, err_pulse, state, digit_cnt, fail_cnt, entry
   );

endinterface
`default_nettype wire

// File: rtl/lock_timer.sv
`default_nettype none
// ============================================================================
// Module   : lock_timer
// Brief    : Loadable down-counter; expired is high while the count equals 1.
// Revision : 1.0 - initial release
// ============================================================================
module lock_timer #(
   parameter int WIDTH = 13
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             expired
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/code_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : code_lock_ctrl
// Brief    : Digit-entry sequencer for a 4-digit code lock with admin reprogram.
//            Define CODE_LOCK_AUTO_ENTER_EN to submit automatically on the last digit.
// Revision : 1.0 - initial release
// ============================================================================
module code_lock_ctrl
   import code_lock_pkg::*;
#(
   parameter int                 DIGITS       = DIGITS_DEF,
   parameter int                 MAX_FAIL     = 3,
   parameter int                 TIMEOUT_CYC  = 1000,
   parameter int                 UNLOCK_CYC   = 2000,
   parameter int                 LOCKOUT_CYC  = 5000,
   parameter logic [ENTRY_W-1:0] DEFAULT_CODE = DEFAULT_CODE_VAL,
   parameter logic [ENTRY_W-1:0] ADMIN_KEY    = ADMIN_KEY_VAL
) (
   input  logic      clk,
   input  logic      rst_n,
   code_lock_if.slave bus
);

   localparam int TMR_MAX_A = (TIMEOUT_CYC > UNLOCK_CYC) ? TIMEOUT_CYC : UNLOCK_CYC;
   localparam int TMR_MAX   = (TMR_MAX_A > LOCKOUT_CYC) ? TMR_MAX_A : LOCKOUT_CYC;
   localparam int TMR_W     = $clog2(TMR_MAX + 1);

   localparam logic [2:0] FULL_CNT = 3'(DIGITS);
   localparam logic [2:0] LAST_CNT = 3'(DIGITS - 1);

   state_e             state_q, state_d;
   logic [ENTRY_W-1:0] entry_q, entry_d;
   logic [ENTRY_W-1:0] code_q, code_d;
   logic [2:0]         cnt_q, cnt_d;
   logic [1:0]         fail_q, fail_d;
   logic               unlock_q, unlock_d;
   logic               alarm_q, alarm_d;
   logic               err_q, err_d;

   logic               tmr_load;
   logic [TMR_W-1:0]   tmr_val;
   logic               tmr_exp;

   logic               take;
   logic               reload;
   logic               fail_hit;
   logic               clear_entry;
   logic [ENTRY_W-1:0] shifted;

   // A digit only counts when no button claims the cycle and there is room for it.
   assign take    = bus.evt_valid && digit_ok(bus.evt_digit) && (cnt_q < FULL_CNT)
                    && !bus.btn_clear && !bus.btn_enter;
   assign shifted = {entry_q[ENTRY_W-DIGIT_W-1:0], bus.evt_digit};

   always_comb begin
      state_d     = state_q;
      entry_d     = entry_q;
      code_d      = code_q;
      cnt_d       = cnt_q;
      fail_d      = fail_q;
      unlock_d    = 1'b0;
      alarm_d     = 1'b0;
      err_d       = 1'b0;
      reload      = 1'b0;
      fail_hit    = 1'b0;
      clear_entry = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (take) begin
               state_d = ST_ENTRY;
               entry_d = shifted;
               cnt_d   = cnt_q + 3'd1;
            end
         end
         ST_ENTRY: begin
            if (bus.btn_clear) begin
               state_d     = ST_IDLE;
               clear_entry = 1'b1;
            end else if (bus.btn_enter) begin
               if (cnt_q == FULL_CNT) state_d = ST_CHECK;
               else                   fail_hit = 1'b1;
            end else if (take) begin
               entry_d = shifted;
               cnt_d   = cnt_q + 3'd1;
               reload  = 1'b1;
`ifdef CODE_LOCK_AUTO_ENTER_EN
               if (cnt_q == LAST_CNT) state_d = ST_CHECK;
`endif
            end else if (tmr_exp) begin
               state_d     = ST_IDLE;
               clear_entry = 1'b1;
            end
         end
         ST_CHECK: begin
            if (!bus.admin_mode && (entry_q == code_q)) begin
               state_d  = ST_OPEN;
               fail_d   = 2'd0;
               unlock_d = 1'b1;
            end else if (bus.admin_mode && (entry_q == ADMIN_KEY)) begin
               state_d     = ST_PROG;
               fail_d      = 2'd0;
               clear_entry = 1'b1;
            end else begin
               fail_hit = 1'b1;
            end
         end
         ST_OPEN: begin
            if (tmr_exp) begin
               state_d     = ST_IDLE;
               clear_entry = 1'b1;
            end else begin
               unlock_d = 1'b1;
            end
         end
         ST_LOCKOUT: begin
            if (tmr_exp) begin
               state_d = ST_IDLE;
               fail_d  = 2'd0;
            end else begin
               alarm_d = 1'b1;
            end
         end
         ST_PROG: begin
            if (bus.btn_clear) begin
               state_d     = ST_IDLE;
               clear_entry = 1'b1;
            end else if (bus.btn_enter) begin
               if (cnt_q == FULL_CNT) begin
                  code_d      = entry_q;
                  state_d     = ST_IDLE;
                  clear_entry = 1'b1;
               end
            end else if (take) begin
               entry_d = shifted;
               cnt_d   = cnt_q + 3'd1;
               reload  = 1'b1;
`ifdef CODE_LOCK_AUTO_ENTER_EN
               if (cnt_q == LAST_CNT) begin
                  code_d      = shifted;
                  state_d     = ST_IDLE;
                  clear_entry = 1'b1;
               end
`endif
            end else if (tmr_exp) begin
               state_d     = ST_IDLE;
               clear_entry = 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            clear_entry = 1'b1;
         end
      endcase

      // Short ENTER in ENTRY and a CHECK mismatch share this failure path.
      if (fail_hit) begin
         err_d       = 1'b1;
         fail_d      = fail_q + 2'd1;
         clear_entry = 1'b1;
         if ((int'(fail_q) + 1) >= MAX_FAIL) begin
            state_d = ST_LOCKOUT;
            alarm_d = 1'b1;
         end else begin
            state_d = ST_IDLE;
         end
      end

      if (clear_entry) begin
         entry_d = ENTRY_EMPTY;
         cnt_d   = 3'd0;
      end
   end

   // Timer is reloaded on every state change and on each accepted digit.
   always_comb begin
      tmr_load = reload || (state_d != state_q);
      tmr_val  = '0;
      unique case (state_d)
         ST_ENTRY, ST_PROG: tmr_val = TMR_W'(TIMEOUT_CYC);
         ST_OPEN:           tmr_val = TMR_W'(UNLOCK_CYC);
         ST_LOCKOUT:        tmr_val = TMR_W'(LOCKOUT_CYC);
         default:           tmr_val = '0;
      endcase
   end

   lock_timer #(
      .WIDTH    (TMR_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_exp)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         entry_q  <= ENTRY_EMPTY;
         code_q   <= DEFAULT_CODE;
         cnt_q    <= 3'd0;
         fail_q   <= 2'd0;
         unlock_q <= 1'b0;
         alarm_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         entry_q  <= entry_d;
         code_q   <= code_d;
         cnt_q    <= cnt_d;
         fail_q   <= fail_d;
         unlock_q <= unlock_d;
         alarm_q  <= alarm_d;
         err_q    <= err_d;
      end
   end

   assign bus.state     = state_q;
   assign bus.entry     = entry_q;
   assign bus.digit_cnt = cnt_q;
   assign bus.fail_cnt  = fail_q;
   assign bus.unlock    = unlock_q;
   assign bus.alarm     = alarm_q;
   assign bus.err_pulse = err_q;

endmodule
`default_nettype wire

// File: tb/tb_code_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_lock_ctrl
// Brief    : Directed self-checking bench for code_lock_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_code_lock_ctrl;
   import code_lock_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   code_lock_if bus ();

   code_lock_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_digit(input logic [3:0] d);
      bus.evt_valid = 1'b1;
      bus.evt_digit = d;
      step();
      bus.evt_valid = 1'b0;
   endtask

   task automatic press_enter();
      bus.btn_enter = 1'b1;
      step();
      bus.btn_enter = 1'b0;
   endtask

   task automatic press_clear();
      bus.btn_clear = 1'b1;
      step();
      bus.btn_clear = 1'b0;
   endtask

   task automatic enter_code(input logic [15:0] c);
      for (int i = 3; i >= 0; i--) send_digit(c[i*4 +: 4]);
`ifndef CODE_LOCK_AUTO_ENTER_EN
      press_enter();
`endif
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.evt_valid = 1'b0; bus.evt_digit = 4'd0;
      bus.btn_enter = 1'b0; bus.btn_clear = 1'b0; bus.admin_mode = 1'b0;
      step(); step();
      rst_n = 1'b1;
      step();
      n_checks++;
      if ({bus.state, bus.digit_cnt, bus.fail_cnt, bus.unlock, bus.alarm, bus.err_pulse} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_flags: got st=%0d cnt=%0d fail=%0d u=%b a=%b e=%b want all 0",
                  bus.state, bus.digit_cnt, bus.fail_cnt, bus.unlock, bus.alarm, bus.err_pulse);
      end
      n_checks++;
      if (bus.entry !== 16'hFFFF) begin
         n_fail++; $display("FAIL reset_entry: got %h want ffff", bus.entry);
      end
   endtask

   task automatic test_unlock();
      int n;
      bus.admin_mode = 1'b0;
      send_digit(4'd1); send_digit(4'd2); send_digit(4'd3); send_digit(4'd4);
      n_checks++;
      if (bus.entry !== 16'h1234) begin
         n_fail++; $display("FAIL unlock_entry: got %h want 1234", bus.entry);
      end
`ifndef CODE_LOCK_AUTO_ENTER_EN
      press_enter();
`endif
      n_checks++;
      if (bus.state !== 3'd2) begin
         n_fail++; $display("FAIL unlock_check_state: got %0d want 2", bus.state);
      end
      step();
      n_checks++;
      if (bus.state !== 3'd3 || bus.unlock !== 1'b1) begin
         n_fail++; $display("FAIL unlock_open: got st=%0d u=%b want st=3 u=1", bus.state, bus.unlock);
      end
      n = 0;
      while (bus.unlock === 1'b1 && n < 3000) begin n++; step(); end
      n_checks++;
      if (n !== 2000) begin
         n_fail++; $display("FAIL unlock_len: got %0d cycles want 2000", n);
      end
      n_checks++;
      if (bus.state !== 3'd0 || bus.entry !== 16'hFFFF) begin
         n_fail++; $display("FAIL unlock_exit: got st=%0d entry=%h want st=0 entry=ffff", bus.state, bus.entry);
      end
   endtask

   task automatic test_lockout();
      int n;
      for (int i = 0; i < 3; i++) begin
         enter_code(16'h5555);
         step();
         n_checks++;
         if (bus.err_pulse !== 1'b1 || bus.fail_cnt !== 2'(i + 1)) begin
            n_fail++;
            $display("FAIL lockout_err%0d: got err=%b fail=%0d want err=1 fail=%0d", i, bus.err_pulse, bus.fail_cnt, i + 1);
         end
         n_checks++;
         if (bus.state !== ((i == 2) ? 3'd4 : 3'd0)) begin
            n_fail++; $display("FAIL lockout_state%0d: got %0d want %0d", i, bus.state, (i == 2) ? 4 : 0);
         end
      end
      n = 0;
      while (bus.alarm === 1'b1 && n < 6000) begin
         n++;
         bus.evt_valid = (n == 10);
         bus.evt_digit = 4'd1;
         step();
         bus.evt_valid = 1'b0;
         if (n == 1) begin
            n_checks++;
            if (bus.err_pulse !== 1'b0) begin
               n_fail++; $display("FAIL lockout_err_width: got %b want 0", bus.err_pulse);
            end
         end
         if (n == 10) begin
            n_checks++;
            if (bus.state !== 3'd4 || bus.digit_cnt !== 3'd0) begin
               n_fail++; $display("FAIL lockout_ignore: got st=%0d cnt=%0d want st=4 cnt=0", bus.state, bus.digit_cnt);
            end
         end
      end
      n_checks++;
      if (n !== 5000) begin
         n_fail++; $display("FAIL lockout_len: got %0d cycles want 5000", n);
      end
      n_checks++;
      if (bus.state !== 3'd0 || bus.fail_cnt !== 2'd0) begin
         n_fail++; $display("FAIL lockout_exit: got st=%0d fail=%0d want st=0 fail=0", bus.state, bus.fail_cnt);
      end
   endtask

   task automatic test_prog();
      int n;
      bus.admin_mode = 1'b1;
      enter_code(16'h9999);
      step();
      n_checks++;
      if (bus.state !== 3'd5 || bus.entry !== 16'hFFFF) begin
         n_fail++; $display("FAIL prog_enter: got st=%0d entry=%h want st=5 entry=ffff", bus.state, bus.entry);
      end
      bus.admin_mode = 1'b0;
      send_digit(4'd4); send_digit(4'd3);
      press_enter();
      n_checks++;
      if (bus.state !== 3'd5 || bus.digit_cnt !== 3'd2) begin
         n_fail++; $display("FAIL prog_short_enter: got st=%0d cnt=%0d want st=5 cnt=2", bus.state, bus.digit_cnt);
      end
      send_digit(4'd2); send_digit(4'd1);
`ifndef CODE_LOCK_AUTO_ENTER_EN
      press_enter();
`endif
      n_checks++;
      if (bus.state !== 3'd0) begin
         n_fail++; $display("FAIL prog_commit: got st=%0d want 0", bus.state);
      end
      enter_code(16'h1234);
      step();
      n_checks++;
      if (bus.err_pulse !== 1'b1 || bus.state !== 3'd0 || bus.fail_cnt !== 2'd1) begin
         n_fail++; $display("FAIL prog_old_code: got err=%b st=%0d fail=%0d want 1 0 1", bus.err_pulse, bus.state, bus.fail_cnt);
      end
      enter_code(16'h4321);
      step();
      n_checks++;
      if (bus.state !== 3'd3 || bus.unlock !== 1'b1 || bus.fail_cnt !== 2'd0) begin
         n_fail++; $display("FAIL prog_new_code: got st=%0d u=%b fail=%0d want 3 1 0", bus.state, bus.unlock, bus.fail_cnt);
      end
      n = 0;
      while (bus.unlock === 1'b1 && n < 3000) begin n++; step(); end
   endtask

   task automatic test_timeout();
      int n;
      send_digit(4'd7);
      press_enter();
      n_checks++;
      if (bus.err_pulse !== 1'b1 || bus.fail_cnt !== 2'd1 || bus.state !== 3'd0) begin
         n_fail++; $display("FAIL partial_enter: got err=%b fail=%0d st=%0d want 1 1 0", bus.err_pulse, bus.fail_cnt, bus.state);
      end
      send_digit(4'd7); send_digit(4'd8);
      n_checks++;
      if (bus.state !== 3'd1 || bus.entry !== 16'hFF78) begin
         n_fail++; $display("FAIL timeout_entry: got st=%0d entry=%h want 1 ff78", bus.state, bus.entry);
      end
      n = 0;
      while (bus.state === 3'd1 && n < 2000) begin n++; step(); end
      n_checks++;
      if (n !== 1000) begin
         n_fail++; $display("FAIL timeout_len: got %0d cycles want 1000", n);
      end
      n_checks++;
      if (bus.state !== 3'd0 || bus.digit_cnt !== 3'd0 || bus.fail_cnt !== 2'd1) begin
         n_fail++; $display("FAIL timeout_exit: got st=%0d cnt=%0d fail=%0d want 0 0 1", bus.state, bus.digit_cnt, bus.fail_cnt);
      end
   endtask

   task automatic test_clear_drop();
      send_digit(4'd1);
      send_digit(4'hC);
      n_checks++;
      if (bus.state !== 3'd1 || bus.digit_cnt !== 3'd1 || bus.entry !== 16'hFFF1) begin
         n_fail++; $display("FAIL bad_digit: got st=%0d cnt=%0d entry=%h want 1 1 fff1", bus.state, bus.digit_cnt, bus.entry);
      end
      bus.btn_clear = 1'b1; bus.evt_valid = 1'b1; bus.evt_digit = 4'd5;
      step();
      bus.btn_clear = 1'b0; bus.evt_valid = 1'b0;
      n_checks++;
      if (bus.state !== 3'd0 || bus.digit_cnt !== 3'd0 || bus.entry !== 16'hFFFF) begin
         n_fail++; $display("FAIL clear_prio: got st=%0d cnt=%0d entry=%h want 0 0 ffff", bus.state, bus.digit_cnt, bus.entry);
      end
      press_enter();
      n_checks++;
      if (bus.state !== 3'd0 || bus.err_pulse !== 1'b0 || bus.fail_cnt !== 2'd1) begin
         n_fail++; $display("FAIL idle_enter: got st=%0d err=%b fail=%0d want 0 0 1", bus.state, bus.err_pulse, bus.fail_cnt);
      end
`ifndef CODE_LOCK_AUTO_ENTER_EN
      send_digit(4'd1); send_digit(4'd2); send_digit(4'd3); send_digit(4'd4); send_digit(4'd9);
      n_checks++;
      if (bus.entry !== 16'h1234 || bus.digit_cnt !== 3'd4 || bus.state !== 3'd1) begin
         n_fail++; $display("FAIL fifth_digit: got entry=%h cnt=%0d st=%0d want 1234 4 1", bus.entry, bus.digit_cnt, bus.state);
      end
      press_clear();
      n_checks++;
      if (bus.state !== 3'd0 || bus.entry !== 16'hFFFF) begin
         n_fail++; $display("FAIL clear_full: got st=%0d entry=%h want 0 ffff", bus.state, bus.entry);
      end
`endif
   endtask

   task automatic test_reset_mid_prog();
      bus.admin_mode = 1'b1;
      enter_code(16'h9999);
      step();
      bus.admin_mode = 1'b0;
      send_digit(4'd5); send_digit(4'd6);
      n_checks++;
      if (bus.state !== 3'd5 || bus.digit_cnt !== 3'd2) begin
         n_fail++; $display("FAIL midprog_setup: got st=%0d cnt=%0d want 5 2", bus.state, bus.digit_cnt);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.state !== 3'd0 || bus.digit_cnt !== 3'd0 || bus.entry !== 16'hFFFF || bus.fail_cnt !== 2'd0) begin
         n_fail++; $display("FAIL async_reset: got st=%0d cnt=%0d entry=%h fail=%0d want 0 0 ffff 0",
                            bus.state, bus.digit_cnt, bus.entry, bus.fail_cnt);
      end
      step();
      rst_n = 1'b1;
      step();
      enter_code(16'h1234);
      step();
      n_checks++;
      if (bus.state !== 3'd3 || bus.unlock !== 1'b1) begin
         n_fail++; $display("FAIL reset_code_restore: got st=%0d u=%b want 3 1", bus.state, bus.unlock);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_unlock();
      test_lockout();
      test_prog();
      test_timeout();
      test_clear_drop();
      test_reset_mid_prog();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/code_lock_ctrl.md
Name: code_lock_ctrl

Overview:
Sequencing controller that consumes the switch-scanner event stream (one digit per switch "Up" event) and drives a 4-digit code lock.
- Assembles digits into an entry word and checks it against the stored user code, or the admin key when in admin mode.
- Drives unlock, failure and lockout behaviour.
- Lets an authenticated admin reprogram the user code.
- Sits between the switch I/O scanner and the display/actuator logic.

Parameters:
DIGITS, 4, digits per code (entry word = 4*DIGITS bits)
MAX_FAIL, 3, consecutive failures that trigger lockout
TIMEOUT_CYC, 1000, idle cycles in ENTRY/PROG before silent abort
UNLOCK_CYC, 2000, cycles UNLOCK stays high
LOCKOUT_CYC, 5000, cycles inputs are ignored during lockout
DEFAULT_CODE, 16'h1234, user code after reset
ADMIN_KEY, 16'h9999, fixed admin key

Ports:
CLK  in  1  single system clock, rising edge
RESET_N  in  1  asynchronous active-low reset
EVT_VALID  in  1  one-cycle pulse: a switch went Up
EVT_DIGIT  in  4  digit of that switch, 0..9; values >9 are ignored
BTN_ENTER  in  1  one-cycle pulse: submit entry
BTN_CLEAR  in  1  one-cycle pulse: abort/clear entry
ADMIN_MODE  in  1  level; sampled in CHECK only
UNLOCK  out  1  lock open
ALARM  out  1  high throughout LOCKOUT
ERR_PULSE  out  1  one-cycle pulse on each failed check
STATE  out  3  current FSM state encoding
DIGIT_CNT  out  3  digits captured so far, 0..DIGITS
FAIL_CNT  out  2  consecutive failures
ENTRY  out  16  captured digits, newest in [3:0]

Behaviour:
- Reset (async, RESET_N low):
  - STATE=IDLE; ENTRY=16'hFFFF; DIGIT_CNT=0; FAIL_CNT=0.
  - UNLOCK, ALARM and ERR_PULSE = 0.
  - User code register = DEFAULT_CODE; timer = 0.
  - Reset mid-operation always returns to this state, including any code being programmed.
- Input priority in the same cycle: BTN_CLEAR > BTN_ENTER > EVT_VALID.
- Digit capture (ENTRY/PROG): valid digit with DIGIT_CNT<DIGITS -> ENTRY <= {ENTRY[11:0],digit}, DIGIT_CNT++. Digits arriving when DIGIT_CNT==DIGITS are dropped.
- Any accepted digit reloads the timeout timer to TIMEOUT_CYC.
- States and transitions:
  - IDLE (0): a valid digit is captured -> ENTRY. BTN_ENTER and BTN_CLEAR are ignored.
  - ENTRY (1):
    - CLEAR -> IDLE, entry cleared.
    - ENTER with DIGIT_CNT==DIGITS -> CHECK.
    - ENTER with DIGIT_CNT<DIGITS counts as a failure (same path as a mismatch in CHECK).
    - Timer expiry -> IDLE, entry cleared, FAIL_CNT unchanged.
  - CHECK (2): exactly one cycle.
    - ADMIN_MODE=0 and ENTRY==code -> OPEN, FAIL_CNT=0.
    - ADMIN_MODE=1 and ENTRY==ADMIN_KEY -> PROG, FAIL_CNT=0.
    - Otherwise: ERR_PULSE=1 and FAIL_CNT++. If the new value equals MAX_FAIL -> LOCKOUT, else -> IDLE. Entry is cleared either way.
  - OPEN (3): UNLOCK=1 for exactly UNLOCK_CYC cycles, then IDLE with entry cleared. All inputs are ignored.
  - LOCKOUT (4): ALARM=1 for exactly LOCKOUT_CYC cycles. All inputs are ignored. Then -> IDLE with FAIL_CNT=0.
  - PROG (5):
    - Entry is cleared on arrival.
    - Collects DIGITS new digits; ENTER with a full count -> code register <= ENTRY -> IDLE.
    - ENTER with fewer digits is ignored.
    - CLEAR or timeout -> IDLE with the code unchanged.
- Timer: one shared down-counter, wide enough for the largest parameter. Reloaded on each state entry; expiry is the cycle it reaches 1.
- Outputs are registered: a state change is visible on STATE one cycle after the causing input.

Optional Feature:
CODE_LOCK_AUTO_ENTER_EN
- Defined: the DIGITS-th accepted digit in ENTRY moves the FSM to CHECK on the next cycle without BTN_ENTER. The same applies in PROG, where the code is committed. BTN_ENTER with a partial entry still fails in ENTRY.
- Undefined: BTN_ENTER is required, as described in Behaviour.

Decomposition:
- Package code_lock_pkg holds:
  - the state encoding constants (IDLE..PROG, 3 bits);
  - the digit width (4) and the entry-word width;
  - the empty-entry value 16'hFFFF;
  - default code and admin key values.
- Sub-module lock_timer: a loadable down-counter with load value, load strobe and expiry output, instantiated once.

Test Plan:
- Digits 1,2,3,4 then ENTER, ADMIN_MODE=0 -> CHECK for 1 cycle, then UNLOCK=1 for exactly 2000 cycles, then IDLE, ENTRY=FFFF.
- Three bad entries (5,5,5,5 + ENTER) -> ERR_PULSE on each; FAIL_CNT 1,2 then LOCKOUT with ALARM=1. Digits during lockout are ignored. After 5000 cycles -> IDLE with FAIL_CNT=0.
- ADMIN_MODE=1, enter 9,9,9,9 + ENTER -> PROG; enter 4,3,2,1 + ENTER -> IDLE. Then 1,2,3,4 fails and 4,3,2,1 unlocks.
- Digits 7,8 then 1000 idle cycles -> IDLE, DIGIT_CNT=0, FAIL_CNT unchanged.
- BTN_CLEAR and a digit in the same cycle while in ENTRY -> IDLE, entry cleared. EVT_DIGIT=4'hC -> ignored. A fifth digit is dropped and ENTRY keeps the first four.
- Assert RESET_N low during PROG after 2 digits -> all outputs reset and the code reverts to 16'h1234; with the macro defined, 1,2,3,4 then unlocks with no ENTER.
